// File: rtl/alu_pkg.sv
// Shared opcode, flag index and per-lane flag types
// for the SIMD ALU pipeline.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SHL  = 4'd2,
        OP_SHR  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NAND = 4'd7,
        OP_NOT  = 4'd8,
        OP_NOR  = 4'd9,
        OP_SRA  = 4'd10,
        OP_MIN  = 4'd11,
        OP_MAX  = 4'd12
    } alu_op_e;

    localparam int FLG_Z  = 0;
    localparam int FLG_N  = 1;
    localparam int FLG_E  = 2;
    localparam int FLG_G  = 3;
    localparam int FLG_L  = 4;
    localparam int FLAG_N = 5;

    // Field order puts zf at bit FLG_Z.
    typedef struct packed {
        logic lf;
        logic gf;
        logic ef;
        logic nf;
        logic zf;
    } lane_flags_t;

endpackage

// File: rtl/alu_lane.sv
// Combinational single-lane datapath: one opcode
// applied to a signed operand pair, plus flags.
module alu_lane
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output lane_flags_t       flags
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] shamt;
    logic            big;
    logic            lt;
    logic            gt;

    // Any set bit above the shift field means b >= DATA_W.
    assign shamt = b[SH_W-1:0];
    assign big   = |b[DATA_W-1:SH_W];
    assign lt    = $signed(a) < $signed(b);
    assign gt    = $signed(a) > $signed(b);

    always_comb begin
        c = '0;
        unique case (op)
            OP_ADD:  c = a + b;
            OP_SUB:  c = a - b;
            OP_SHL:  c = big ? '0 : a << shamt;
            OP_SHR:  c = big ? '0 : a >> shamt;
            OP_AND:  c = a & b;
            OP_OR:   c = a | b;
            OP_XOR:  c = a ^ b;
            OP_NAND: c = ~(a & b);
            OP_NOT:  c = ~a;
            OP_NOR:  c = ~(a | b);
            OP_SRA: begin
                if (big) c = {DATA_W{a[DATA_W-1]}};
                else     c = $signed(a) >>> shamt;
            end
            OP_MIN:  c = lt ? a : b;
            OP_MAX:  c = gt ? a : b;
            default: c = '0;
        endcase
    end

    always_comb begin
        flags    = '0;
        flags.zf = (c == '0);
        flags.nf = c[DATA_W-1];
        flags.ef = (c == a);
        flags.gf = gt;
        flags.lf = lt;
    end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage valid/ready SIMD ALU: stage 1 holds operands,
// stage 2 holds masked per-lane results and flags.
module simd_alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int TAG_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic [LANES-1:0]        in_mask,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_c,
    output logic [LANES-1:0]        out_zf,
    output logic [LANES-1:0]        out_nf,
    output logic [LANES-1:0]        out_ef,
    output logic [LANES-1:0]        out_gf,
    output logic [LANES-1:0]        out_lf,
    output logic [LANES-1:0]        out_mask,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int VW = LANES * DATA_W;

    logic             s1_valid;
    logic             s1_ready;
    logic             s2_valid;
    logic             s2_ready;
    alu_op_e          s1_op;
    logic [LANES-1:0] s1_mask;
    logic [TAG_W-1:0] s1_tag;
    logic [VW-1:0]    s1_a;
    logic [VW-1:0]    s1_b;

    logic [VW-1:0]    c_nxt;
    logic [LANES-1:0] zf_nxt;
    logic [LANES-1:0] nf_nxt;
    logic [LANES-1:0] ef_nxt;
    logic [LANES-1:0] gf_nxt;
    logic [LANES-1:0] lf_nxt;

    assign s2_ready  = !s2_valid || out_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_mask  <= '0;
            s1_tag   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= alu_op_e'(in_op);
                s1_mask <= in_mask;
                s1_tag  <= in_tag;
                s1_a    <= in_a;
                s1_b    <= in_b;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] c;
        lane_flags_t       f;

        alu_lane #(
            .DATA_W(DATA_W)
        ) u_lane (
            .op   (s1_op),
            .a    (s1_a[i*DATA_W +: DATA_W]),
            .b    (s1_b[i*DATA_W +: DATA_W]),
            .c    (c),
            .flags(f)
        );

        // Disabled lanes report zero result and no flags.
        assign c_nxt[i*DATA_W +: DATA_W] =
            s1_mask[i] ? c : '0;
        assign zf_nxt[i] = s1_mask[i] & f[FLG_Z];
        assign nf_nxt[i] = s1_mask[i] & f[FLG_N];
        assign ef_nxt[i] = s1_mask[i] & f[FLG_E];
        assign gf_nxt[i] = s1_mask[i] & f[FLG_G];
        assign lf_nxt[i] = s1_mask[i] & f[FLG_L];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_c    <= '0;
            out_zf   <= '0;
            out_nf   <= '0;
            out_ef   <= '0;
            out_gf   <= '0;
            out_lf   <= '0;
            out_mask <= '0;
            out_tag  <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_c    <= c_nxt;
                out_zf   <= zf_nxt;
                out_nf   <= nf_nxt;
                out_ef   <= ef_nxt;
                out_gf   <= gf_nxt;
                out_lf   <= lf_nxt;
                out_mask <= s1_mask;
                out_tag  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe with directed
// vectors and hand-computed per-lane expectations.
module tb_simd_alu_pipe;

    localparam int DW = 32;
    localparam int L  = 4;
    localparam int TW = 6;
    localparam int VW = DW * L;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] SHL = 4'd2;
    localparam logic [3:0] SHR = 4'd3;
    localparam logic [3:0] OR_ = 4'd5;
    localparam logic [3:0] XOR = 4'd6;
    localparam logic [3:0] NOT = 4'd8;
    localparam logic [3:0] SRA = 4'd10;
    localparam logic [3:0] MIN = 4'd11;
    localparam logic [3:0] MAX = 4'd12;
    localparam logic [3:0] RSV = 4'd13;

    typedef logic [255:0] w_t;

    typedef struct {
        logic [VW-1:0] c;
        logic [L-1:0]  zf, nf, ef, gf, lf, mask;
        logic [TW-1:0] tag;
        int            cyc;
        bit            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [L-1:0]  in_mask;
    logic [VW-1:0] in_a;
    logic [VW-1:0] in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_c;
    logic [L-1:0]  out_zf, out_nf, out_ef;
    logic [L-1:0]  out_gf, out_lf, out_mask;
    logic [TW-1:0] out_tag;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   saw_stall = 0;
    bit   held_v = 0;
    w_t   held;
    exp_t q[$];

    simd_alu_pipe #(
        .DATA_W(DW),
        .LANES (L),
        .TAG_W (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_mask  (in_mask),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_c    (out_c),
        .out_zf   (out_zf),
        .out_nf   (out_nf),
        .out_ef   (out_ef),
        .out_gf   (out_gf),
        .out_lf   (out_lf),
        .out_mask (out_mask),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] pk(
        input logic [DW-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic w_t snap();
        return w_t'({out_c, out_zf, out_nf, out_ef,
                     out_gf, out_lf, out_mask, out_tag});
    endfunction

    task automatic cmp(input string nm,
                       input w_t act, input w_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, exp);
        end
    endtask

    task automatic send(
        input logic [3:0] op, input logic [L-1:0] m,
        input logic [VW-1:0] a, b, input logic [TW-1:0] t,
        input logic [VW-1:0] c,
        input logic [L-1:0] zf, nf, ef, gf, lf,
        input bit lat);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        in_op    = op;
        in_mask  = m;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            saw_stall = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready 0 want 1");
        end else begin
            e = '{c: c, zf: zf, nf: nf, ef: ef, gf: gf,
                  lf: lf, mask: m, tag: t, cyc: cyc,
                  lat: lat};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && q.size() != 0; n++)
            @(posedge clk);
        #1;
        cmp("drain_empty", w_t'(q.size()), w_t'(0));
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, "_valid"}, w_t'(out_valid), w_t'(0));
        cmp({nm, "_outs"}, snap(), w_t'(0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                cmp("hold_valid", w_t'(out_valid), w_t'(1));
                cmp("hold_data", snap(), held);
            end
            held_v = out_valid && !out_ready;
            held   = snap();
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stale_out: got tag %0h want none",
                             out_tag);
                end else begin
                    e = q.pop_front();
                    cmp("c", w_t'(out_c), w_t'(e.c));
                    cmp("zf", w_t'(out_zf), w_t'(e.zf));
                    cmp("nf", w_t'(out_nf), w_t'(e.nf));
                    cmp("ef", w_t'(out_ef), w_t'(e.ef));
                    cmp("gf", w_t'(out_gf), w_t'(e.gf));
                    cmp("lf", w_t'(out_lf), w_t'(e.lf));
                    cmp("mask", w_t'(out_mask), w_t'(e.mask));
                    cmp("tag", w_t'(out_tag), w_t'(e.tag));
                    if (e.lat)
                        cmp("latency", w_t'(cyc - e.cyc), w_t'(2));
                end
            end
        end
    end

    initial begin
        logic [TW-1:0] t;
        in_valid  = 1'b0;
        in_op     = '0;
        in_mask   = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        cmp("reset_in_ready", w_t'(in_ready), w_t'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(ADD, 4'hF,
             pk(32'd1, 32'h7FFFFFFF, 32'hFFFFFFFB, 32'd0),
             pk(32'd2, 32'd1, 32'd5, 32'd0), 6'h01,
             pk(32'd3, 32'h80000000, 32'd0, 32'd0),
             4'b1100, 4'b0010, 4'b1000, 4'b0010, 4'b0101, 1);
        repeat (4) @(posedge clk);
        #1;

        send(SRA, 4'hF, {4{32'h80000000}},
             pk(32'd4, 32'd40, 32'd0, 32'd32), 6'h02,
             pk(32'hF8000000, 32'hFFFFFFFF,
                32'h80000000, 32'hFFFFFFFF),
             4'b0000, 4'b1111, 4'b0100, 4'b0000, 4'b1111, 0);
        send(SHR, 4'hF, {4{32'h80000000}},
             pk(32'd4, 32'd40, 32'd0, 32'd32), 6'h03,
             pk(32'h08000000, 32'd0, 32'h80000000, 32'd0),
             4'b1010, 4'b0100, 4'b0100, 4'b0000, 4'b1111, 0);
        send(SHL, 4'hF, {4{32'h80000000}},
             pk(32'd4, 32'd40, 32'd0, 32'd32), 6'h04,
             pk(32'd0, 32'd0, 32'h80000000, 32'd0),
             4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b1111, 0);
        send(XOR, 4'b0101,
             pk(32'hF0F0F0F0, 32'd1, 32'h12345678, 32'd5),
             pk(32'h0F0F0F0F, 32'd1, 32'h12345678, 32'd7),
             6'h05,
             pk(32'hFFFFFFFF, 32'd0, 32'd0, 32'd0),
             4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0);
        send(MIN, 4'hF,
             pk(32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000),
             pk(32'd1, 32'hFFFFFFFD, 32'd7, 32'h7FFFFFFF),
             6'h06,
             pk(32'hFFFFFFFF, 32'hFFFFFFFD, 32'd7, 32'h80000000),
             4'b0000, 4'b1011, 4'b1101, 4'b0010, 4'b1001, 0);
        send(MAX, 4'hF,
             pk(32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000),
             pk(32'd1, 32'hFFFFFFFD, 32'd7, 32'h7FFFFFFF),
             6'h07,
             pk(32'd1, 32'd5, 32'd7, 32'h7FFFFFFF),
             4'b0000, 4'b0000, 4'b0110, 4'b0010, 4'b1001, 0);
        send(SUB, 4'hF,
             pk(32'd0, 32'd10, 32'h80000000, 32'd3),
             pk(32'd1, 32'd3, 32'd1, 32'd3), 6'h08,
             pk(32'hFFFFFFFF, 32'd7, 32'h7FFFFFFF, 32'd0),
             4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0101, 0);
        send(NOT, 4'hF,
             pk(32'd0, 32'hFFFFFFFF, 32'h0000FFFF, 32'hAAAAAAAA),
             {4{32'd0}}, 6'h09,
             pk(32'hFFFFFFFF, 32'd0, 32'hFFFF0000, 32'h55555555),
             4'b0010, 4'b0101, 4'b0000, 4'b0100, 4'b1010, 0);
        send(RSV, 4'hF,
             pk(32'd0, 32'd5, 32'hFFFFFFFF, 32'd3),
             pk(32'd0, 32'd1, 32'd2, 32'd3), 6'h0A,
             {4{32'd0}},
             4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 0);
        send(ADD, 4'h0,
             pk(32'd1, 32'd2, 32'd3, 32'd4),
             pk(32'd1, 32'd2, 32'd3, 32'd4), 6'h0B,
             {4{32'd0}},
             4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        drain();

        saw_stall = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    t = TW'($urandom_range(0, 63));
                    send(ADD, 4'hF, {4{32'(i)}}, {4{32'd0}}, t,
                         {4{32'(i)}}, 4'b0000, 4'b0000,
                         4'b1111, 4'b1111, 4'b0000, 0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        cmp("in_ready_drop", w_t'(saw_stall), w_t'(1));

        send(ADD, 4'hF, {4{32'd1}}, {4{32'd1}}, 6'h11,
             {4{32'd2}}, 4'b0000, 4'b0000, 4'b0000,
             4'b0000, 4'b0000, 0);
        send(ADD, 4'hF, {4{32'd2}}, {4{32'd2}}, 6'h12,
             {4{32'd4}}, 4'b0000, 4'b0000, 4'b0000,
             4'b0000, 4'b0000, 0);
        cmp("pre_reset_valid", w_t'(out_valid), w_t'(1));
        rst = 1'b1;
        #1;
        check_zero("midreset");
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_zero("post_reset");
        send(OR_, 4'hF,
             pk(32'd1, 32'd2, 32'd4, 32'd8),
             pk(32'd16, 32'd32, 32'd64, 32'd128), 6'h2A,
             pk(32'd17, 32'd34, 32'd68, 32'd136),
             4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
